// File: rtl/reg_load_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : reg_load_ctrl_if
// Brief  : Load handshake bundle between control unit and reg_load_ctrl.
// Rev    : 1.0 - initial release
// ============================================================================
interface reg_load_ctrl_if #(
    parameter int WORD_SIZE = 19,
    parameter int SEL_W     = 3,
    parameter int LEN_W     = 3
);
    logic                 load_valid;
    logic                 load_ready;
    logic [SEL_W-1:0]     load_sel;
    logic [LEN_W-1:0]     load_len;
    logic [WORD_SIZE-1:0] load_data;
    logic                 busy;
    logic                 load_done;

    modport master (
        output load_valid, load_sel, load_len, load_data,
        input  load_ready, busy, load_done
    );

    modport slave (
        input  load_valid, load_sel, load_len, load_data,
        output load_ready, busy, load_done
    );
endinterface
`default_nettype wire

// File: rtl/reg_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module : reg_load_ctrl
// Brief  : Register-load controller with burst loads, PC increment, read ports.
// Rev    : 1.0 - initial release
// ============================================================================
module reg_load_ctrl #(
    parameter int WORD_SIZE = 19,
    parameter int NUM_REGS  = 5,
    parameter int SEL_W     = 3,
    parameter int PC_INC    = 1,
    parameter int MAX_BURST = 4,
    localparam int LEN_W    = $clog2(MAX_BURST + 1)
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    reg_load_ctrl_if.slave            load_if,
    input  wire logic                 stall,
    input  wire logic                 pc_inc,
    output logic                      sel_err,
    input  wire logic                 err_clr,
    input  wire logic [SEL_W-1:0]     rd_sel_a,
    output logic      [WORD_SIZE-1:0] rd_data_a,
    input  wire logic [SEL_W-1:0]     rd_sel_b,
    output logic      [WORD_SIZE-1:0] rd_data_b,
    output logic      [WORD_SIZE-1:0] pc_out
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    // One extra bit so NUM_REGS == 2**SEL_W is representable.
    localparam logic [SEL_W:0]     c_num_regs  = (SEL_W + 1)'(NUM_REGS);
    localparam logic [LEN_W-1:0]   c_max_burst = LEN_W'(MAX_BURST);
    localparam logic [WORD_SIZE-1:0] c_pc_inc  = WORD_SIZE'(PC_INC);

    logic [0:0]           r_state;
    logic [LEN_W-1:0]     r_remain;
    logic [SEL_W-1:0]     r_idx;
    logic                 r_done;
    logic                 r_err;
    logic [WORD_SIZE-1:0] r_regs [NUM_REGS];

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_sel_ok;
    logic [LEN_W-1:0]     w_eff_len;
    logic [SEL_W-1:0]     w_wr_idx;
    logic                 w_wr_en;
    logic [SEL_W:0]       w_idx_inc;
    logic [SEL_W-1:0]     w_next_idx;
    logic                 w_last;

    assign w_ready = !stall && rst_n;

    always_comb begin
        w_accept = load_if.load_valid && w_ready;
        w_sel_ok = {1'b0, load_if.load_sel} < c_num_regs;

        if (load_if.load_len == '0)
            w_eff_len = LEN_W'(1);
        else if (load_if.load_len > c_max_burst)
            w_eff_len = c_max_burst;
        else
            w_eff_len = load_if.load_len;

        w_wr_idx   = (r_state == S_BURST) ? r_idx : load_if.load_sel;
        w_wr_en    = w_accept && ((r_state == S_BURST) || w_sel_ok);
        w_idx_inc  = {1'b0, w_wr_idx} + (SEL_W + 1)'(1);
        w_next_idx = (w_idx_inc == c_num_regs) ? '0 : w_idx_inc[SEL_W-1:0];

        // An out-of-range select completes immediately as an error load.
        if (r_state == S_IDLE)
            w_last = !w_sel_ok || (w_eff_len == LEN_W'(1));
        else
            w_last = (r_remain == LEN_W'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_remain <= '0;
            r_idx    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_accept && w_last;
            if (w_accept) begin
                if (r_state == S_IDLE) begin
                    if (!w_last) begin
                        r_state  <= S_BURST;
                        r_remain <= w_eff_len - LEN_W'(1);
                        r_idx    <= w_next_idx;
                    end
                end else begin
                    r_remain <= r_remain - LEN_W'(1);
                    r_idx    <= w_next_idx;
                    if (w_last)
                        r_state <= S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_err <= 1'b0;
        else if (w_accept && (r_state == S_IDLE) && !w_sel_ok)
            r_err <= 1'b1;
        else if (err_clr)
            r_err <= 1'b0;
    end

    // Load write is ordered after the PC increment so it takes priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= '0;
        end else begin
            if (pc_inc)
                r_regs[0] <= r_regs[0] + c_pc_inc;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_en && (w_wr_idx == SEL_W'(i)))
                    r_regs[i] <= load_if.load_data;
            end
        end
    end

    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if ({1'b0, rd_sel_a} == (SEL_W + 1)'(i))
                rd_data_a = r_regs[i];
            if ({1'b0, rd_sel_b} == (SEL_W + 1)'(i))
                rd_data_b = r_regs[i];
        end
    end

    assign load_if.load_ready = w_ready;
    assign load_if.busy       = (r_state == S_BURST);
    assign load_if.load_done  = r_done;
    assign sel_err            = r_err;
    assign pc_out             = r_regs[0];

endmodule
`default_nettype wire

// File: tb/tb_reg_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_reg_load_ctrl
// Brief  : Directed self-checking bench for reg_load_ctrl.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_reg_load_ctrl;

    localparam int WORD_SIZE = 19;
    localparam int SEL_W     = 3;
    localparam int LEN_W     = 3;

    logic                 clk;
    logic                 rst_n;
    logic                 stall;
    logic                 pc_inc;
    logic                 sel_err;
    logic                 err_clr;
    logic [SEL_W-1:0]     rd_sel_a;
    logic [WORD_SIZE-1:0] rd_data_a;
    logic [SEL_W-1:0]     rd_sel_b;
    logic [WORD_SIZE-1:0] rd_data_b;
    logic [WORD_SIZE-1:0] pc_out;

    int n_cmp;
    int n_err;

    reg_load_ctrl_if #(.WORD_SIZE(WORD_SIZE), .SEL_W(SEL_W), .LEN_W(LEN_W)) lif ();

    reg_load_ctrl #(
        .WORD_SIZE(WORD_SIZE), .NUM_REGS(5), .SEL_W(SEL_W), .PC_INC(1), .MAX_BURST(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load_if(lif.slave), .stall(stall), .pc_inc(pc_inc),
        .sel_err(sel_err), .err_clr(err_clr), .rd_sel_a(rd_sel_a), .rd_data_a(rd_data_a),
        .rd_sel_b(rd_sel_b), .rd_data_b(rd_data_b), .pc_out(pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [SEL_W-1:0] sel,
                         input logic [LEN_W-1:0] len, input logic [WORD_SIZE-1:0] d);
        @(negedge clk);
        lif.load_valid = v;
        lif.load_sel   = sel;
        lif.load_len   = len;
        lif.load_data  = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rd_sel_a = 3'd2;
        rd_sel_b = 3'd4;
        #1;
        n_cmp++; if (pc_out !== 19'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", pc_out); end
        n_cmp++; if (rd_data_a !== 19'h0 || rd_data_b !== 19'h0) begin n_err++; $display("FAIL reset_regs got %h/%h want 0", rd_data_a, rd_data_b); end
        n_cmp++; if (lif.busy !== 1'b0 || lif.load_done !== 1'b0 || sel_err !== 1'b0) begin n_err++; $display("FAIL reset_flags got busy=%b done=%b err=%b want 0", lif.busy, lif.load_done, sel_err); end
        n_cmp++; if (lif.load_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", lif.load_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        drive(1'b1, 3'd2, 3'd1, 19'h1ABCD);
        #1;
        n_cmp++; if (lif.load_ready !== 1'b1) begin n_err++; $display("FAIL single_ready got %b want 1", lif.load_ready); end
        n_cmp++; if (rd_data_a !== 19'h0) begin n_err++; $display("FAIL single_nobypass got %h want 0", rd_data_a); end
        step();
        n_cmp++; if (rd_data_a !== 19'h1ABCD) begin n_err++; $display("FAIL single_data got %h want 1abcd", rd_data_a); end
        n_cmp++; if (lif.load_done !== 1'b1 || lif.busy !== 1'b0) begin n_err++; $display("FAIL single_done got done=%b busy=%b want 1/0", lif.load_done, lif.busy); end
        drive(1'b0, 3'd0, 3'd0, 19'h0);
        step();
        n_cmp++; if (lif.load_done !== 1'b0) begin n_err++; $display("FAIL single_pulse got %b want 0", lif.load_done); end
    endtask

    task automatic test_burst();
        logic [WORD_SIZE-1:0] d [4];
        int busy_cnt;
        d[0] = 19'h11; d[1] = 19'h22; d[2] = 19'h33; d[3] = 19'h44;
        busy_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i == 0) ? 3'd3 : 3'd6, (i == 0) ? 3'd4 : 3'd1, d[i]);
            step();
            if (lif.busy === 1'b1) busy_cnt++;
            if (i < 3) begin
                n_cmp++; if (lif.load_done !== 1'b0) begin n_err++; $display("FAIL burst_early_done beat %0d got 1 want 0", i); end
            end
        end
        n_cmp++; if (busy_cnt !== 3) begin n_err++; $display("FAIL burst_busy_cycles got %0d want 3", busy_cnt); end
        n_cmp++; if (lif.load_done !== 1'b1 || lif.busy !== 1'b0) begin n_err++; $display("FAIL burst_done got done=%b busy=%b want 1/0", lif.load_done, lif.busy); end
        drive(1'b0, 3'd0, 3'd0, 19'h0);
        rd_sel_a = 3'd3; rd_sel_b = 3'd4;
        #1;
        n_cmp++; if (rd_data_a !== 19'h11 || rd_data_b !== 19'h22) begin n_err++; $display("FAIL burst_r3r4 got %h/%h want 11/22", rd_data_a, rd_data_b); end
        rd_sel_a = 3'd1; rd_sel_b = 3'd2;
        #1;
        n_cmp++; if (pc_out !== 19'h33 || rd_data_a !== 19'h44) begin n_err++; $display("FAIL burst_wrap got pc=%h r1=%h want 33/44", pc_out, rd_data_a); end
        n_cmp++; if (rd_data_b !== 19'h1ABCD) begin n_err++; $display("FAIL burst_r2_kept got %h want 1abcd", rd_data_b); end
    endtask

    task automatic test_gaps();
        drive(1'b1, 3'd2, 3'd3, 19'hA1);
        step();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            stall = 1'b1;
            lif.load_data = 19'h0BAD;
            #1;
            n_cmp++; if (lif.load_ready !== 1'b0) begin n_err++; $display("FAIL gap_ready cycle %0d got %b want 0", i, lif.load_ready); end
            step();
        end
        drive(1'b0, 3'd0, 3'd0, 19'h0BAD);
        stall = 1'b0;
        step();
        rd_sel_a = 3'd3;
        #1;
        n_cmp++; if (rd_data_a !== 19'h11 || lif.busy !== 1'b1) begin n_err++; $display("FAIL gap_hold got r3=%h busy=%b want 11/1", rd_data_a, lif.busy); end
        drive(1'b1, 3'd0, 3'd1, 19'hA2);
        step();
        drive(1'b1, 3'd0, 3'd1, 19'hA3);
        step();
        n_cmp++; if (lif.load_done !== 1'b1 || lif.busy !== 1'b0) begin n_err++; $display("FAIL gap_done got done=%b busy=%b want 1/0", lif.load_done, lif.busy); end
        drive(1'b0, 3'd0, 3'd0, 19'h0);
        rd_sel_a = 3'd2; rd_sel_b = 3'd3;
        #1;
        n_cmp++; if (rd_data_a !== 19'hA1 || rd_data_b !== 19'hA2) begin n_err++; $display("FAIL gap_r2r3 got %h/%h want a1/a2", rd_data_a, rd_data_b); end
        rd_sel_a = 3'd4; rd_sel_b = 3'd1;
        #1;
        n_cmp++; if (rd_data_a !== 19'hA3 || rd_data_b !== 19'h44 || pc_out !== 19'h33) begin n_err++; $display("FAIL gap_others got r4=%h r1=%h pc=%h want a3/44/33", rd_data_a, rd_data_b, pc_out); end
    endtask

    task automatic test_pc();
        drive(1'b1, 3'd0, 3'd1, 19'h7FFFF);
        step();
        drive(1'b0, 3'd0, 3'd0, 19'h0);
        pc_inc = 1'b1;
        step();
        n_cmp++; if (pc_out !== 19'h00000) begin n_err++; $display("FAIL pc_wrap got %h want 0", pc_out); end
        drive(1'b1, 3'd0, 3'd1, 19'h100);
        step();
        n_cmp++; if (pc_out !== 19'h100) begin n_err++; $display("FAIL pc_load_wins got %h want 100", pc_out); end
        drive(1'b0, 3'd0, 3'd0, 19'h0);
        step();
        n_cmp++; if (pc_out !== 19'h101) begin n_err++; $display("FAIL pc_inc got %h want 101", pc_out); end
        @(negedge clk);
        pc_inc = 1'b0;
    endtask

    task automatic test_len_edges();
        drive(1'b1, 3'd1, 3'd0, 19'h2222);
        step();
        rd_sel_a = 3'd1;
        #1;
        n_cmp++; if (rd_data_a !== 19'h2222 || lif.load_done !== 1'b1 || lif.busy !== 1'b0) begin n_err++; $display("FAIL len0 got r1=%h done=%b busy=%b want 2222/1/0", rd_data_a, lif.load_done, lif.busy); end
        drive(1'b1, 3'd4, 3'd7, 19'hC1);
        step();
        drive(1'b1, 3'd4, 3'd7, 19'hC2);
        step();
        drive(1'b1, 3'd4, 3'd7, 19'hC3);
        step();
        drive(1'b1, 3'd4, 3'd7, 19'hC4);
        step();
        n_cmp++; if (lif.load_done !== 1'b1 || lif.busy !== 1'b0) begin n_err++; $display("FAIL len_cap got done=%b busy=%b want 1/0", lif.load_done, lif.busy); end
        drive(1'b0, 3'd0, 3'd0, 19'h0);
        rd_sel_a = 3'd4; rd_sel_b = 3'd2;
        #1;
        n_cmp++; if (rd_data_a !== 19'hC1 || rd_data_b !== 19'hC4 || pc_out !== 19'hC2) begin n_err++; $display("FAIL len_cap_data got r4=%h r2=%h pc=%h want c1/c4/c2", rd_data_a, rd_data_b, pc_out); end
        rd_sel_a = 3'd5; rd_sel_b = 3'd7;
        #1;
        n_cmp++; if (rd_data_a !== 19'h0 || rd_data_b !== 19'h0) begin n_err++; $display("FAIL rd_out_of_range got %h/%h want 0", rd_data_a, rd_data_b); end
    endtask

    task automatic test_sel_err();
        drive(1'b1, 3'd6, 3'd4, 19'h5555);
        step();
        n_cmp++; if (sel_err !== 1'b1 || lif.load_done !== 1'b1 || lif.busy !== 1'b0) begin n_err++; $display("FAIL err_set got err=%b done=%b busy=%b want 1/1/0", sel_err, lif.load_done, lif.busy); end
        drive(1'b0, 3'd0, 3'd0, 19'h0);
        rd_sel_a = 3'd4; rd_sel_b = 3'd1;
        step();
        n_cmp++; if (pc_out !== 19'hC2 || rd_data_a !== 19'hC1 || rd_data_b !== 19'hC3) begin n_err++; $display("FAIL err_nowrite got pc=%h r4=%h r1=%h want c2/c1/c3", pc_out, rd_data_a, rd_data_b); end
        n_cmp++; if (sel_err !== 1'b1 || lif.load_done !== 1'b0) begin n_err++; $display("FAIL err_sticky got err=%b done=%b want 1/0", sel_err, lif.load_done); end
        drive(1'b1, 3'd7, 3'd1, 19'h6666);
        err_clr = 1'b1;
        step();
        n_cmp++; if (sel_err !== 1'b1 || lif.load_done !== 1'b1) begin n_err++; $display("FAIL err_set_wins got err=%b done=%b want 1/1", sel_err, lif.load_done); end
        drive(1'b0, 3'd0, 3'd0, 19'h0);
        step();
        n_cmp++; if (sel_err !== 1'b0) begin n_err++; $display("FAIL err_clear got %b want 0", sel_err); end
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        drive(1'b1, 3'd1, 3'd4, 19'h61);
        step();
        drive(1'b1, 3'd1, 3'd4, 19'h62);
        step();
        n_cmp++; if (lif.busy !== 1'b1) begin n_err++; $display("FAIL mid_busy got %b want 1", lif.busy); end
        drive(1'b0, 3'd0, 3'd0, 19'h0);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (lif.load_ready !== 1'b0) begin n_err++; $display("FAIL mid_ready got %b want 0", lif.load_ready); end
        step();
        rd_sel_a = 3'd1; rd_sel_b = 3'd2;
        #1;
        n_cmp++; if (pc_out !== 19'h0 || rd_data_a !== 19'h0 || rd_data_b !== 19'h0) begin n_err++; $display("FAIL mid_regs got pc=%h r1=%h r2=%h want 0", pc_out, rd_data_a, rd_data_b); end
        n_cmp++; if (lif.busy !== 1'b0 || lif.load_done !== 1'b0) begin n_err++; $display("FAIL mid_flags got busy=%b done=%b want 0/0", lif.busy, lif.load_done); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 3'd4, 3'd1, 19'h77);
        step();
        rd_sel_a = 3'd4;
        #1;
        n_cmp++; if (rd_data_a !== 19'h77 || lif.load_done !== 1'b1 || lif.busy !== 1'b0) begin n_err++; $display("FAIL post_reset got r4=%h done=%b busy=%b want 77/1/0", rd_data_a, lif.load_done, lif.busy); end
        n_cmp++; if (pc_out !== 19'h0 || rd_data_b !== 19'h0) begin n_err++; $display("FAIL post_reset_others got pc=%h r2=%h want 0", pc_out, rd_data_b); end
        drive(1'b0, 3'd0, 3'd0, 19'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        stall = 1'b0;
        pc_inc = 1'b0;
        err_clr = 1'b0;
        rd_sel_a = '0;
        rd_sel_b = '0;
        lif.load_valid = 1'b0;
        lif.load_sel = '0;
        lif.load_len = '0;
        lif.load_data = '0;
        test_reset();
        test_single();
        test_burst();
        test_gaps();
        test_pc();
        test_len_edges();
        test_sel_err();
        test_reset_mid_burst();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_load_ctrl.md
Name: reg_load_ctrl

Overview:
Parametrised register-load controller. Generalises the fixed five-entry LOAD_SELECT decode (PC, IR, A, B, C) to NUM_REGS word-wide registers. Adds a valid/ready load handshake, multi-beat burst loads into consecutive registers, PC auto-increment, and a sticky select-error flag. It sits between the CPU control unit/memory interface and the datapath, and provides two combinational read ports.

Parameters:
WORD_SIZE, 19, data/register width in bits
NUM_REGS, 5, number of registers; index 0=PC, 1=IR, 2=A, 3=B, 4=C, 5+=general
SEL_W, 3, select field width; must satisfy 2**SEL_W >= NUM_REGS
PC_INC, 1, amount added to PC on pc_inc
MAX_BURST, 4, maximum beats per burst; LEN_W = $clog2(MAX_BURST+1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
load_valid  input  1  load beat offered
load_ready  output  1  controller accepts a beat this cycle
load_sel  input  SEL_W  start register index; sampled on first beat only
load_len  input  LEN_W  burst beat count; sampled on first beat only
load_data  input  WORD_SIZE  write data for the current beat
stall  input  1  pipeline hold; forces load_ready low
pc_inc  input  1  increment PC by PC_INC
busy  output  1  burst in progress (BURST state)
load_done  output  1  one-cycle pulse after the last beat of a load is accepted
sel_err  output  1  sticky: out-of-range select seen
err_clr  input  1  clears sel_err
rd_sel_a  input  SEL_W  read port A index
rd_data_a  output  WORD_SIZE  register[rd_sel_a], combinational
rd_sel_b  input  SEL_W  read port B index
rd_data_b  output  WORD_SIZE  register[rd_sel_b], combinational
pc_out  output  WORD_SIZE  register 0, always visible

Behaviour:
- Reset, sampled on a clk edge with rst_n=0: all registers 0, state IDLE, busy=0, load_done=0, sel_err=0, internal beat counter and index 0. Reset in the middle of a burst abandons the burst. No partial state survives.
- load_ready = !stall && rst_n, in both IDLE and BURST. A beat is accepted when load_valid && load_ready.
- IDLE, beat accepted:
  - If load_sel >= NUM_REGS: no write, sel_err<=1, load_done pulses next cycle, stay IDLE.
  - Else write load_data to reg[load_sel]. Effective length L = (load_len==0) ? 1 : min(load_len, MAX_BURST).
  - If L==1: load_done pulses next cycle, stay IDLE.
  - Otherwise go to BURST with remaining = L-1 and next index = (load_sel+1) mod NUM_REGS.
- BURST, beat accepted: write to the next index; index advances mod NUM_REGS (wrap-around, e.g. 4 -> 0). Decrement remaining. When the last beat is accepted, return to IDLE and pulse load_done next cycle. load_sel and load_len are ignored in BURST. busy=1 throughout BURST.
- Gaps: load_valid low or stall high in BURST holds state indefinitely. There is no timeout.
- Write timing: the write is visible on read ports and pc_out the cycle after acceptance. Read ports are combinational from registers, with no bypass. A rd_sel >= NUM_REGS reads 0.
- PC increment: on pc_inc, PC <= (PC + PC_INC) mod 2**WORD_SIZE. If a load beat writes index 0 in the same cycle, the load wins and the increment is dropped.
- sel_err: err_clr clears it. If err_clr and a new error occur in the same cycle, the set wins.
- load_done is a registered pulse, exactly one cycle per completed load, including error loads.

Test Plan:
- Reset then single load sel=2, len=1, data=0x1ABCD -> rd_data_a (sel 2)=0x1ABCD one cycle later; load_done one pulse; busy stays 0.
- Burst sel=3, len=4, data 0x11,0x22,0x33,0x44 -> reg3=0x11, reg4=0x22, reg0(PC)=0x33 (wrap), reg1=0x44; busy high 3 cycles; load_done after the 4th beat.
- Burst len=3 with stall asserted 2 cycles between beats 1 and 2 and load_valid low 1 cycle -> load_ready low during stall; final contents unchanged by the gaps; no extra writes.
- PC at 0x7FFFF with pc_inc -> PC=0x00000 (wrap). Same-cycle pc_inc with a load to sel=0, data=0x100 -> PC=0x100.
- load_sel=6 -> no register changes; sel_err=1 and stays set; err_clr with a simultaneous sel=7 load keeps it 1; err_clr alone clears it.
- rst_n low mid-burst (after 2 of 4 beats) -> all registers 0, busy=0, IDLE; a following single load works normally.
